// File: rtl/srrc_matched_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : srrc_matched_rx
// Purpose  : Receive-side 21-tap square-root-raised-cosine matched filter,
//            symbol-rate decimator and Gray-coded 4-ASK slicer.
//            Pipeline: accept/shift (E) -> MAC into acc (E+1) -> decimate,
//            scale, slice and strobe (E+2).
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous active-high reset
//            samp_in    - signed 8-bit oversampled channel sample
//            samp_valid - samp_in accepted when high
//            phase_sel  - decimation phase 0..SPS-1 (>= SPS treated as 0)
//            symb_out   - signed 8-bit filtered symbol-rate sample
//            bits_out   - Gray-coded 2-bit decision for symb_out
//            symb_valid - one-cycle strobe for new symb_out/bits_out
//            locked     - high once the delay line has filled
// Config   : SRRC_RX_SAT_EN - when defined, symb_out saturates to
//            [-128,127]; otherwise acc[23:16] is taken with wrap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module srrc_matched_rx #(
  parameter int SPS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [7:0] samp_in,
  input  logic              samp_valid,
  input  logic [2:0]        phase_sel,
  output logic signed [7:0] symb_out,
  output logic [1:0]        bits_out,
  output logic              symb_valid,
  output logic              locked
);

  // Signed 1.14 taps c[0..10]; c[k] = c[20-k], so only half is stored.
  localparam logic signed [15:0] c_coef [0:10] = '{
    -16'sd171,  16'sd265,   16'sd453,   -16'sd85,    -16'sd1145, -16'sd1604,
    -16'sd2,    16'sd4318,  16'sd10364, 16'sd15720,  16'sd17862
  };
  localparam logic [4:0] c_last_fill = 5'd20;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [4:0]            r_fill_cnt, w_fill_cnt_nxt;
  logic                  w_eligible;
  logic signed [7:0]     r_dly [0:20];
  logic signed [8:0]     w_pre [0:10];
  logic signed [25:0]    w_prod [0:10];
  logic signed [25:0]    w_acc;
  logic signed [25:0]    r_acc;
  logic                  r_v1, r_v2;
  logic [2:0]            r_ph;
  logic [2:0]            w_phase_eff;
  logic                  w_ph_wrap;
  logic signed [7:0]     w_symb;
  logic [1:0]            w_bits;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FILL;
      r_fill_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_cnt_nxt;
    end
  end

  // w_eligible marks an accepted sample whose MAC result may be emitted;
  // the 21st sample during FILL is the first such sample.
  always_comb begin
    w_state_nxt    = r_state;
    w_fill_cnt_nxt = r_fill_cnt;
    w_eligible     = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (samp_valid) begin
          if (r_fill_cnt == c_last_fill) begin
            w_state_nxt = ST_RUN;
            w_eligible  = 1'b1;
          end else begin
            w_fill_cnt_nxt = r_fill_cnt + 5'd1;
          end
        end
      end
      ST_RUN:  w_eligible = samp_valid;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  assign locked = (r_state == ST_RUN);

  // ---------------------------------------------------------- delay line
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 21; k++) r_dly[k] <= '0;
    end else if (samp_valid) begin
      r_dly[0] <= samp_in;
      for (int k = 1; k < 21; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  // ------------------------------------------------- folded symmetric MAC
  // Pre-add of mirrored taps fits in 9 bits; each product and the running
  // sum are kept at full 26-bit precision.
  always_comb begin
    for (int k = 0; k < 10; k++)
      w_pre[k] = 9'(r_dly[k]) + 9'(r_dly[20-k]);
    w_pre[10] = 9'(r_dly[10]);
    w_acc = '0;
    for (int k = 0; k < 11; k++) begin
      w_prod[k] = w_pre[k] * c_coef[k];
      w_acc     = w_acc + w_prod[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_acc <= '0;
    end else begin
      r_v1 <= w_eligible;
      r_v2 <= r_v1;
      if (r_v1) r_acc <= w_acc;
    end
  end

  // ------------------------------------------------ scale, slice, decimate
`ifdef SRRC_RX_SAT_EN
  logic signed [9:0] w_y;
  assign w_y = r_acc[25:16];  // acc >>> 16
  always_comb begin
    if (w_y > 10'sd127)       w_symb = 8'sd127;
    else if (w_y < -10'sd128) w_symb = -8'sd128;
    else                      w_symb = w_y[7:0];
  end
`else
  assign w_symb = r_acc[23:16];
`endif

  always_comb begin
    if (w_symb < -8'sd64)     w_bits = 2'b00;
    else if (w_symb < 8'sd0)  w_bits = 2'b01;
    else if (w_symb < 8'sd64) w_bits = 2'b11;
    else                      w_bits = 2'b10;
  end

  assign w_phase_eff = (int'(phase_sel) >= SPS) ? 3'd0 : phase_sel;
  assign w_ph_wrap   = (r_ph == 3'(SPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph       <= '0;
      symb_out   <= '0;
      bits_out   <= '0;
      symb_valid <= 1'b0;
    end else begin
      symb_valid <= 1'b0;
      if (r_v2) begin
        r_ph <= w_ph_wrap ? 3'd0 : r_ph + 3'd1;
        if (r_ph == w_phase_eff) begin
          symb_out   <= w_symb;
          bits_out   <= w_bits;
          symb_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srrc_matched_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_srrc_matched_rx
// Purpose  : Directed self-checking bench for srrc_matched_rx. A second
//            instance with SPS = 1 traces the impulse response.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_srrc_matched_rx;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] samp_in;
  logic              samp_valid;
  logic [2:0]        phase_sel;
  logic signed [7:0] symb_out,   symb_out1;
  logic [1:0]        bits_out,   bits_out1;
  logic              symb_valid, symb_valid1;
  logic              locked,     locked1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  srrc_matched_rx #(.SPS(4)) dut (
    .clk(clk), .reset(reset), .samp_in(samp_in), .samp_valid(samp_valid),
    .phase_sel(phase_sel), .symb_out(symb_out), .bits_out(bits_out),
    .symb_valid(symb_valid), .locked(locked)
  );

  srrc_matched_rx #(.SPS(1)) dut1 (
    .clk(clk), .reset(reset), .samp_in(samp_in), .samp_valid(samp_valid),
    .phase_sel(phase_sel), .symb_out(symb_out1), .bits_out(bits_out1),
    .symb_valid(symb_valid1), .locked(locked1)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic signed [7:0] s);
    samp_valid = v;
    samp_in    = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] gray(input int y);
    if (y < -64)     return 2'b00;
    else if (y < 0)  return 2'b01;
    else if (y < 64) return 2'b11;
    else             return 2'b10;
  endfunction

  // floor(127*c[k]/65536), k = 0..20
  int imp_exp [0:20] = '{-1, 0, 0, -1, -3, -4, -1, 8, 20, 30, 34,
                         30, 20, 8, -1, -4, -3, -1, 0, 0, -1};

  // One DC section: 40 samples then 2 flush cycles; strobes counted and
  // settled values checked once the delay line is full of the DC level.
  task automatic dc_run(input string tag, input logic signed [7:0] lvl,
                        input int exp_y, input logic [1:0] exp_b);
    int nstb = 0;
    for (int s = 1; s <= 42; s++) begin
      step(s <= 40, (s <= 40) ? lvl : 8'sd0);
      if (symb_valid === 1'b1) begin
        nstb++;
        if (s >= 23) begin
          check({tag, "_y"}, symb_out, exp_y);
          check({tag, "_bits"}, {30'd0, bits_out}, {30'd0, exp_b});
        end
      end
    end
    check({tag, "_strobes"}, nstb, 10);
  endtask

  initial begin
    reset = 1'b1; samp_valid = 1'b0; samp_in = '0; phase_sel = 3'd0;

    // ---- reset / fill
    step(0, 0);
    step(0, 0);
    check("rst_symb",   symb_out, 0);
    check("rst_bits",   {30'd0, bits_out}, 0);
    check("rst_valid",  {31'd0, symb_valid}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 0);
      check("fill_valid",  {31'd0, symb_valid}, 0);
      check("fill_locked", {31'd0, locked}, 0);
    end
    step(1, 0);
    check("lock_edge",       {31'd0, locked}, 1);
    check("lock_valid",      {31'd0, symb_valid}, 0);
    step(0, 0);
    check("first_lat1",      {31'd0, symb_valid}, 0);
    step(0, 0);
    check("first_valid",     {31'd0, symb_valid}, 1);
    check("first_symb",      symb_out, 0);
    check("first_bits",      {30'd0, bits_out}, {30'd0, 2'b11});
    step(0, 0);
    check("first_drop",      {31'd0, symb_valid}, 0);

    // ---- DC levels
    dc_run("dc_p64", 8'sd64, 72, 2'b10);
    dc_run("dc_m64", -8'sd64, -73, 2'b00);
`ifdef SRRC_RX_SAT_EN
    dc_run("dc_p127", 8'sd127, 127, 2'b10);
`else
    dc_run("dc_p127", 8'sd127, -113, 2'b00);
`endif

    // ---- impulse through the SPS = 1 instance
    for (int t = 0; t < 44; t++) begin
      step(t < 42, (t == 21) ? 8'sd127 : 8'sd0);
      if (t >= 23) begin
        check("imp_valid", {31'd0, symb_valid1}, 1);
        check("imp_y",     symb_out1, imp_exp[t-23]);
        check("imp_bits",  {30'd0, bits_out1}, {30'd0, gray(imp_exp[t-23])});
      end
    end

    // ---- mid-run reset with a result in flight
    step(1, 8'sd50);
    reset = 1'b1;
    step(1, 8'sd50);
    check("mrst_valid",   {31'd0, symb_valid}, 0);
    check("mrst_valid1",  {31'd0, symb_valid1}, 0);
    check("mrst_symb",    symb_out, 0);
    check("mrst_symb1",   symb_out1, 0);
    check("mrst_bits1",   {30'd0, bits_out1}, 0);
    check("mrst_locked",  {31'd0, locked}, 0);
    check("mrst_locked1", {31'd0, locked1}, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      check("mrst_quiet",  {31'd0, symb_valid}, 0);
      check("mrst_quiet1", {31'd0, symb_valid1}, 0);
    end

    // ---- phase change and idle gaps
    for (int i = 0; i < 21; i++) step(1, 8'sd64);
    check("ph_locked", {31'd0, locked}, 1);
    step(0, 0);
    step(0, 0);
    check("ph_first_valid", {31'd0, symb_valid}, 1);
    check("ph_first_symb",  symb_out, 72);
    phase_sel = 3'd2;
    for (int k = 1; k <= 8; k++) begin
      logic exp_v;
      if (k == 7) phase_sel = 3'd5;   // out of range -> phase 0
      exp_v = (k == 2) || (k == 6) || (k == 8);
      step(1, 8'sd64);
      check("gap_acc_valid", {31'd0, symb_valid}, 0);
      step(0, 0);
      check("gap_e1_valid",  {31'd0, symb_valid}, 0);
      step(0, 0);
      check("gap_e2_valid",  {31'd0, symb_valid}, {31'd0, exp_v});
      if (exp_v) check("gap_e2_symb", symb_out, 72);
      step(0, 0);
      check("gap_e3_valid",  {31'd0, symb_valid}, 0);
      check("gap_hold_symb", symb_out, 72);
      check("gap_hold_bits", {30'd0, bits_out}, {30'd0, 2'b10});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/srrc_matched_rx.md
# srrc_matched_rx

Receive-side matched filter and symbol sampler for the square-root-raised-cosine (SRRC) link. It takes the oversampled 8-bit channel stream and runs it through a 21-tap SRRC filter matched to the transmit pulse. It then decimates to one sample per symbol at a selectable phase and slices each symbol into a Gray-coded 2-bit 4-ASK decision. It sits between the channel/ADC model and the symbol-to-bit unpacker.

## Interface
- `SPS`, default 4: samples per symbol (decimation factor); legal range 2..8.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `samp_in` in signed 8: oversampled channel sample.
- `samp_valid` in 1: `samp_in` is accepted on a rising edge where this is high; may stay high every cycle.
- `phase_sel` in 3: decimation phase, 0..SPS-1; values of SPS or more are treated as 0.
- `symb_out` out signed 8: filtered symbol-rate sample.
- `bits_out` out 2: Gray-coded slicer decision for `symb_out`.
- `symb_valid` out 1: one-cycle strobe marking a new `symb_out`/`bits_out`.
- `locked` out 1: high once the delay line has filled (state RUN).

## Operation
- **Coefficients:** 21 taps in signed 1.14 format, symmetric, c[k] = c[20-k].
  - c[0..10] = -171, 265, 453, -85, -1145, -1604, -2, 4318, 10364, 15720, 17862.
  - Hard-wired constants; symmetric pre-add folding of tap pairs is permitted.
- **Delay line:** 21 × 8-bit registers, d[0] newest. It shifts on each accepted sample.
- **MAC:** acc = Σ c[k]·d[k], held in a full-precision 26-bit signed register. It is not truncated before the sum completes.
- **Scaling:** y = acc >>> 16 (arithmetic shift, floor).
- **Decimator:** phase counter `ph`, range 0..SPS-1.
  - Increments modulo SPS per MAC result in RUN; resets to 0.
  - A symbol is emitted when `ph` == `phase_sel` at the MAC-result cycle.
  - `phase_sel` is sampled each cycle, so a change takes effect on the next MAC result.
- **Slicer (Gray code):**
  - y < -64 → 00
  - -64 ≤ y < 0 → 01
  - 0 ≤ y < 64 → 11
  - y ≥ 64 → 10
  - The slicer uses the final 8-bit `symb_out` value.
- **State machine:**
  - FILL: counts accepted samples; no `symb_valid` is issued. After the 21st accepted sample, go to RUN.
  - RUN: normal output; `locked` = 1. Only `reset` leaves RUN.
- **Reset values:**
  - `symb_out` = 0, `bits_out` = 00, `symb_valid` = 0, `locked` = 0.
  - Delay line, acc, `ph` and fill count are all zero; state = FILL.
- **Reset mid-operation:** discards all in-flight pipeline results; no `symb_valid` is issued on or after the reset edge until 21 new samples have been accepted.
- **Idle input:** if `samp_valid` is low, no MAC result is produced, `ph` holds and the outputs hold their last values. `symb_valid` is 0.

## Timing
- Edge E: sample accepted, delay line shifts.
- Edge E+1: acc captures the MAC of the updated delay line; a valid flag is pipelined alongside.
- Edge E+2: if in RUN and `ph` matches, `symb_out`, `bits_out` and `symb_valid` = 1 register. `symb_valid` drops at E+3 unless the next sample also qualifies.
- Latency is a fixed 2 clocks from the accept edge to the output strobe.
- Throughput is one sample per clock; at most one `symb_valid` per SPS accepted samples in steady state.
- The transition to RUN occurs at the edge that accepts sample 21. That sample's MAC result is the first eligible for output; `ph` starts at 0 for it.
- `locked` rises at the same edge as the state change.

## Configuration
- `SRRC_RX_SAT_EN` defined: `symb_out` = y saturated to [-128, 127].
- `SRRC_RX_SAT_EN` undefined: `symb_out` = acc[23:16], plain truncation with wrap.
- The slicer acts on `symb_out` in both cases.

## Test plan
- **Reset / fill:** hold `reset` 2 cycles, then 20 samples of 0 → `symb_valid` stays 0 and `locked` stays 0. On the 21st sample, `locked` = 1 at that edge, and `symb_valid` = 1 with `symb_out` = 0 two clocks later (SPS = 4, `phase_sel` = 0).
- **DC +64:** SPS = 4, 40 samples of 64 → steady `symb_out` = 72, `bits_out` = 10, one strobe every 4 samples. DC -64 → `symb_out` = -73, `bits_out` = 00.
- **DC +127:**
  - With `SRRC_RX_SAT_EN` → `symb_out` = 127, `bits_out` = 10.
  - Without → `symb_out` = -113, `bits_out` = 00.
- **Impulse:** after lock, a single 127 followed by zeros, SPS = 1 (bench override) → outputs trace floor(127·c[k]/65536): -1, 0, 0, -1, -3, -4, -1, 8, 20, 30, 34, 30, … symmetric.
- **Phase / idle:** `phase_sel` switched 0 → 2 mid-stream, with `samp_valid` gaps of 3 cycles → strobes move to `ph` = 2, the 2-clock latency is measured from each accept edge, and outputs hold during gaps.
- **Mid-run reset:** assert `reset` while a result is in the pipe → no strobe for the discarded sample; all outputs return to 0 and `locked` = 0.
